// File: rtl/fma_pipe_param.sv
// Four-stage parametrised floating-point multiply-add (a*b+c, a*b-c, a*b, a+c) with valid/ready flow control.
// Optional build macro FMA_PIPE_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fma_pipe_param #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int SIDE_W = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]     a_in,
  input  logic [1+EXP_W+MAN_W-1:0]     b_in,
  input  logic [1+EXP_W+MAN_W-1:0]     c_in,
  input  logic [1:0]                   op_in,
  input  logic [SIDE_W-1:0]            side_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1+EXP_W+MAN_W-1:0]     result,
  output logic [SIDE_W-1:0]            side_out,
  output logic [3:0]                   flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MW;
  localparam int FW   = PW + 3;
  localparam int SW   = FW + 1;
  localparam int EX   = EXP_W + 2;
  localparam int LW   = $clog2(SW);
  localparam int EI   = EX + LW + 2;

  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EI-1:0]    EMAX     = EI'((1 << EXP_W) - 1);

  logic advance;
  logic v1, v2, v3, v4;

  assign advance   = !v4 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v4;

  // ---------------- S1: operand select, unpack, classify ----------------
  logic [W-1:0]       b_eff, c_eff;
  logic               sa, sb, sc;
  logic [EXP_W-1:0]   ea, eb, ec;
  logic [MAN_W-1:0]   fa, fb, fc;
  logic               za, zb, zc, ia, ib, ic, na, nb, nc, sp;
  logic               spec_hit, spec_inv;
  logic [W-1:0]       spec_res;

  always_comb begin
    b_eff = b_in;
    c_eff = c_in;
    case (op_in)
      2'b01:   c_eff = {~c_in[W-1], c_in[W-2:0]};
      2'b10:   c_eff = '0;
      2'b11:   b_eff = {1'b0, EXP_W'(BIAS), {MAN_W{1'b0}}};
      default: ;
    endcase
  end

  assign {sa, ea, fa} = a_in;
  assign {sb, eb, fb} = b_eff;
  assign {sc, ec, fc} = c_eff;
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign zc = (ec == '0);
  assign ia = (ea == EXP_ONES) && (fa == '0);
  assign ib = (eb == EXP_ONES) && (fb == '0);
  assign ic = (ec == EXP_ONES) && (fc == '0);
  assign na = (ea == EXP_ONES) && (fa != '0);
  assign nb = (eb == EXP_ONES) && (fb != '0);
  assign nc = (ec == EXP_ONES) && (fc != '0);
  assign sp = sa ^ sb;

  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = QNAN;
    if (na || nb || nc) begin
      spec_inv = 1'b0;
    end else if ((ia && zb) || (za && ib)) begin
      spec_inv = 1'b1;
    end else if ((ia || ib) && ic && (sp != sc)) begin
      spec_inv = 1'b1;
    end else if (ia || ib) begin
      spec_res = {sp, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ic) begin
      spec_res = {sc, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [SIDE_W-1:0]  side1;
  logic               hit1, inv1, sp1, sc1, pz1, cz1;
  logic [W-1:0]       sres1;
  logic [EXP_W-1:0]   ea1, eb1, ec1;
  logic [MW-1:0]      ma1, mb1, mc1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0; side1 <= '0; hit1 <= 1'b0; inv1 <= 1'b0; sres1 <= '0;
      sp1 <= 1'b0; sc1 <= 1'b0; pz1 <= 1'b0; cz1 <= 1'b0;
      ea1 <= '0; eb1 <= '0; ec1 <= '0; ma1 <= '0; mb1 <= '0; mc1 <= '0;
    end else if (advance) begin
      v1    <= in_valid;
      side1 <= side_in;
      hit1  <= spec_hit;
      inv1  <= spec_inv;
      sres1 <= spec_res;
      sp1   <= sp;
      sc1   <= sc;
      pz1   <= za || zb;
      cz1   <= zc;
      ea1   <= ea;
      eb1   <= eb;
      ec1   <= ec;
      // Denormals flush to zero by dropping the hidden bit and the fraction.
      ma1   <= za ? '0 : {1'b1, fa};
      mb1   <= zb ? '0 : {1'b1, fb};
      mc1   <= zc ? '0 : {1'b1, fc};
    end
  end

  // ---------------- S2: mantissa multiply, exponent sum ----------------
  logic signed [EX-1:0] ep_raw;
  assign ep_raw = EX'(ea1) + EX'(eb1) - EX'(BIAS);

  logic [SIDE_W-1:0]    side2;
  logic                 hit2, inv2, sp2, sc2, zneg2;
  logic [W-1:0]         sres2;
  logic [PW-1:0]        pm2;
  logic [MW-1:0]        mc2;
  logic signed [EX-1:0] ep2, ec2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0; side2 <= '0; hit2 <= 1'b0; inv2 <= 1'b0; sres2 <= '0;
      sp2 <= 1'b0; sc2 <= 1'b0; zneg2 <= 1'b0; pm2 <= '0; mc2 <= '0; ep2 <= '0; ec2 <= '0;
    end else if (advance) begin
      v2    <= v1;
      side2 <= side1;
      hit2  <= hit1;
      inv2  <= inv1;
      sres2 <= sres1;
      sp2   <= sp1;
      sc2   <= sc1;
      zneg2 <= pz1 && cz1 && sp1 && sc1;
      pm2   <= PW'(ma1) * PW'(mb1);
      mc2   <= mc1;
      // A zero operand borrows the other's exponent so it never dominates alignment.
      ep2   <= pz1 ? EX'(ec1) : ep_raw;
      ec2   <= cz1 ? ep_raw : EX'(ec1);
    end
  end

  // ---------------- S3: align and add/subtract ----------------
  logic [FW-1:0] xp, xc, xbig, xsml, xsh, mask;
  logic [EX:0]   de;
  logic [SW-1:0] sum;
  logic          p_big, sat, sgn;

  always_comb begin
    xp    = {pm2, 3'b000};
    xc    = {1'b0, mc2, {(MAN_W + 3){1'b0}}};
    p_big = (ep2 >= ec2);
    de    = p_big ? ({ep2[EX-1], ep2} - {ec2[EX-1], ec2})
                  : ({ec2[EX-1], ec2} - {ep2[EX-1], ep2});
    xbig  = p_big ? xp : xc;
    xsml  = p_big ? xc : xp;
    sat   = (32'(de) >= 32'(FW));
    mask  = ~({FW{1'b1}} << de);
    if (sat) xsh = {{(FW-1){1'b0}}, |xsml};
    else     xsh = (xsml >> de) | {{(FW-1){1'b0}}, |(xsml & mask)};
    if (sp2 == sc2) begin
      sum = {1'b0, xbig} + {1'b0, xsh};
      sgn = sp2;
    end else if (xbig >= xsh) begin
      sum = {1'b0, xbig - xsh};
      sgn = p_big ? sp2 : sc2;
    end else begin
      sum = {1'b0, xsh - xbig};
      sgn = p_big ? sc2 : sp2;
    end
  end

  logic [SIDE_W-1:0]    side3;
  logic                 hit3, inv3, sgn3, zneg3;
  logic [W-1:0]         sres3;
  logic [SW-1:0]        sum3;
  logic signed [EX-1:0] e3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3 <= 1'b0; side3 <= '0; hit3 <= 1'b0; inv3 <= 1'b0; sres3 <= '0;
      sgn3 <= 1'b0; zneg3 <= 1'b0; sum3 <= '0; e3 <= '0;
    end else if (advance) begin
      v3    <= v2;
      side3 <= side2;
      hit3  <= hit2;
      inv3  <= inv2;
      sres3 <= sres2;
      sgn3  <= sgn;
      zneg3 <= zneg2;
      sum3  <= sum;
      e3    <= p_big ? ep2 : ec2;
    end
  end

  // ---------------- S4: normalise, round, pack ----------------
  logic [LW-1:0]         lead;
  logic [SW-2:0]         nrm;
  logic signed [EI-1:0]  en;
  logic [MAN_W-1:0]      man;
  logic                  g, r, st;
  logic [W-1:0]          res_n;
  logic [3:0]            flg_n;
`ifdef FMA_PIPE_ROUND_NEAREST_EN
  logic                  inc, cy;
`endif

  always_comb begin
    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum3[i]) lead = LW'(i);
    end
    // Hidden bit lands just above the kept field and is dropped.
    nrm = (SW-1)'(sum3 << (LW'(SW - 1) - lead));
    en  = EI'(e3) + EI'(lead) - EI'(FW - 2);
    man = nrm[SW-2 -: MAN_W];
    g   = nrm[SW-2-MAN_W];
    r   = nrm[SW-3-MAN_W];
    st  = |nrm[SW-4-MAN_W:0];
`ifdef FMA_PIPE_ROUND_NEAREST_EN
    inc = g && (r || st || man[0]);
    {cy, man} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    if (cy) en = en + EI'(1);
`endif
    res_n = {sgn3, en[EXP_W-1:0], man};
    flg_n = {3'b000, g | r | st};
    if (hit3) begin
      res_n = sres3;
      flg_n = {inv3, 3'b000};
    end else if (sum3 == '0) begin
      res_n = {zneg3, {(W-1){1'b0}}};
      flg_n = 4'b0000;
    end else if (en >= EMAX) begin
      res_n = {sgn3, EXP_ONES, {MAN_W{1'b0}}};
      flg_n = 4'b0101;
    end else if (en[EI-1] || en == '0) begin
      res_n = {sgn3, {(W-1){1'b0}}};
      flg_n = 4'b0011;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v4 <= 1'b0; result <= '0; side_out <= '0; flags <= '0;
    end else if (advance) begin
      v4       <= v3;
      result   <= res_n;
      side_out <= side3;
      flags    <= flg_n;
    end
  end

endmodule
